cp0_exc_regs: RTL and testbench

- Parametrised coprocessor-0 exception register block. Replaces the separate EPC, Cause and Status registers with one unit.
- Holds Status, Cause and EPC, services MTC0/MFC0, and performs atomic exception entry and ERET return.
- Synchronises external interrupt lines and produces a masked interrupt request for the control FSM.
- Sits beside the multicycle controller. The controller sequences exception entry; this block owns all CP0 state.

---
 rtl/cp0_exc_regs.sv | 160 ++++++++++++++++
 tb/tb_cp0_exc_regs.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_regs.sv
// CP0 exception register block: Status/Cause/EPC, MTC0/MFC0, exception entry, ERET, IRQ sync.
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
module cp0_exc_regs #(
  parameter int PC_W        = 30,
  parameter int NUM_IRQ     = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               mtc0_we,
  input  logic [4:0]         mtc0_addr,
  input  logic [31:0]        mtc0_data,
  input  logic [4:0]         mfc0_addr,
  output logic [31:0]        mfc0_data,
  input  logic               exc_req,
  input  logic [4:0]         exc_code,
  input  logic [PC_W-1:0]    exc_pc,
  input  logic               exc_bd,
  input  logic               eret,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_pending,
  output logic [PC_W-1:0]    epc_out,
  output logic               exl_out
);

  logic                 ie_q, ie_d, exl_q, exl_d, bd_q, bd_d, pend_q, pend_d;
  logic [7:0]           im_q, im_d, ip;
  logic [1:0]           ipsw_q, ipsw_d;
  logic [4:0]           code_q, code_d;
  logic [PC_W-1:0]      epc_q, epc_d;
  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
  logic                 wr_ok;

  // Exception entry and ERET both swallow a same-cycle MTC0.
  assign wr_ok = mtc0_we & ~exc_req & ~eret;

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, count_d, cmp_q, cmp_d;
  logic        tgl_q, ti_q, ti_d;

  // TI sets when an increment brings Count onto Compare; a Count write wins over the increment.
  always_comb begin
    count_d = count_q;
    cmp_d   = cmp_q;
    ti_d    = ti_q;
    if (wr_ok && mtc0_addr == 5'd9) begin
      count_d = mtc0_data;
    end else if (tgl_q) begin
      count_d = count_q + 32'd1;
      if (count_d == cmp_q) ti_d = 1'b1;
    end
    if (wr_ok && mtc0_addr == 5'd11) begin
      cmp_d = mtc0_data;
      ti_d  = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count_q <= '0;
      cmp_q   <= '0;
      tgl_q   <= 1'b0;
      ti_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      cmp_q   <= cmp_d;
      tgl_q   <= ~tgl_q;
      ti_q    <= ti_d;
    end
  end
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
  end

  always_comb begin
    ip                = '0;
    ip[2 +: NUM_IRQ]  = sync_q[SYNC_STAGES-1];
    ip[1:0]           = ipsw_q;
`ifdef CP0_TIMER_EN
    ip[7]             = ip[7] | ti_q;
`endif
  end

  always_comb begin
    ie_d   = ie_q;
    exl_d  = exl_q;
    im_d   = im_q;
    bd_d   = bd_q;
    ipsw_d = ipsw_q;
    code_d = code_q;
    epc_d  = epc_q;
    if (exc_req) begin
      // Nested entry keeps the original return point.
      if (!exl_q) begin
        epc_d = exc_bd ? exc_pc - PC_W'(1) : exc_pc;
        bd_d  = exc_bd;
      end
      code_d = exc_code;
      exl_d  = 1'b1;
    end else if (eret) begin
      exl_d = 1'b0;
    end else if (mtc0_we) begin
      case (mtc0_addr)
        5'd12: begin
          ie_d  = mtc0_data[0];
          exl_d = mtc0_data[1];
          im_d  = mtc0_data[15:8];
        end
        5'd13:   ipsw_d = mtc0_data[9:8];
        5'd14:   epc_d  = mtc0_data[PC_W+1:2];
        default: ;
      endcase
    end
    pend_d = ~exc_req & ie_q & ~exl_q & |(ip & im_q);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ie_q   <= 1'b0;
      exl_q  <= 1'b0;
      im_q   <= '0;
      bd_q   <= 1'b0;
      ipsw_q <= '0;
      code_q <= '0;
      epc_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      ie_q   <= ie_d;
      exl_q  <= exl_d;
      im_q   <= im_d;
      bd_q   <= bd_d;
      ipsw_q <= ipsw_d;
      code_q <= code_d;
      epc_q  <= epc_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    mfc0_data = '0;
    case (mfc0_addr)
      5'd12:   mfc0_data = {16'h0, im_q, 6'h0, exl_q, ie_q};
      5'd13:   mfc0_data = {bd_q, 15'h0, ip, 1'b0, code_q, 2'b00};
      5'd14:   mfc0_data = 32'({epc_q, 2'b00});
`ifdef CP0_TIMER_EN
      5'd9:    mfc0_data = count_q;
      5'd11:   mfc0_data = cmp_q;
`endif
      default: ;
    endcase
  end

  assign irq_pending = pend_q;
  assign epc_out     = epc_q;
  assign exl_out     = exl_q;

endmodule

// File: tb/tb_cp0_exc_regs.sv
// Directed bench for cp0_exc_regs: per-cycle comparison against a register-map model plus literal spot checks.
module tb_cp0_exc_regs;
  localparam int PC_W = 30, NUM_IRQ = 6, S = 2;

  logic               Clk = 1'b0, Reset;
  logic               mtc0_we, exc_req, exc_bd, eret;
  logic [4:0]         mtc0_addr, mfc0_addr, exc_code;
  logic [31:0]        mtc0_data, mfc0_data;
  logic [PC_W-1:0]    exc_pc, epc_out;
  logic [NUM_IRQ-1:0] irq_in;
  logic               irq_pending, exl_out;

  int checks = 0, errors = 0;

  always #5 Clk = ~Clk;

  cp0_exc_regs #(.PC_W(PC_W), .NUM_IRQ(NUM_IRQ), .SYNC_STAGES(S)) dut (
    .Clk(Clk), .Reset(Reset), .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr),
    .mtc0_data(mtc0_data), .mfc0_addr(mfc0_addr), .mfc0_data(mfc0_data),
    .exc_req(exc_req), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .eret(eret), .irq_in(irq_in), .irq_pending(irq_pending),
    .epc_out(epc_out), .exl_out(exl_out)
  );

  // Architectural model: named fields plus a history of sampled interrupt levels.
  bit                 m_ie, m_exl, m_bd, m_pend, m_np;
  bit [7:0]           m_im;
  bit [1:0]           m_sw;
  bit [4:0]           m_code;
  bit [PC_W-1:0]      m_epc;
  bit [NUM_IRQ-1:0]   hist[$];

  function automatic bit [7:0] m_ip();
    bit [7:0] v;
    v = '0;
    if (hist.size() >= S) v[2 +: NUM_IRQ] = hist[S-1];
    v[1:0] = m_sw;
    return v;
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    case (a)
      5'd12:   return {16'h0, m_im, 6'h0, m_exl, m_ie};
      5'd13:   return {m_bd, 15'h0, m_ip(), 1'b0, m_code, 2'b00};
      5'd14:   return {m_epc, 2'b00};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_ie = 0; m_exl = 0; m_bd = 0; m_pend = 0; m_im = 0; m_sw = 0; m_code = 0; m_epc = 0;
      hist.delete();
    end else begin
      m_np = !exc_req && m_ie && !m_exl && ((m_ip() & m_im) != 8'h0);
      if (exc_req) begin
        if (!m_exl) begin
          m_epc = exc_bd ? exc_pc - 1 : exc_pc;
          m_bd  = exc_bd;
        end
        m_code = exc_code;
        m_exl  = 1;
      end else if (eret) begin
        m_exl = 0;
      end else if (mtc0_we) begin
        if (mtc0_addr == 5'd12) begin
          m_ie = mtc0_data[0]; m_exl = mtc0_data[1]; m_im = mtc0_data[15:8];
        end else if (mtc0_addr == 5'd13) m_sw = mtc0_data[9:8];
        else if (mtc0_addr == 5'd14) m_epc = mtc0_data[31:2];
      end
      hist.push_front(irq_in);
      if (hist.size() > S) void'(hist.pop_back());
      m_pend = m_np;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (Reset === 1'b1) begin
      chk("mfc0_data", mfc0_data, m_rd(mfc0_addr));
      chk("epc_out", 32'(epc_out), 32'(m_epc));
      chk("exl_out", 32'(exl_out), 32'(m_exl));
      chk("irq_pending", 32'(irq_pending), 32'(m_pend));
    end
  end

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    mtc0_we = 1; mtc0_addr = a; mtc0_data = d;
    tick();
    mtc0_we = 0;
  endtask

  task automatic rdchk(input string n, input logic [4:0] a, input logic [31:0] e);
    mfc0_addr = a; #1;
    chk(n, mfc0_data, e);
  endtask

  task automatic exc(input logic [4:0] c, input logic [PC_W-1:0] pc, input logic bd);
    exc_req = 1; exc_code = c; exc_pc = pc; exc_bd = bd;
    tick();
    exc_req = 0;
  endtask

  initial begin
    Reset = 0; mtc0_we = 0; exc_req = 0; eret = 0; exc_bd = 0;
    mtc0_addr = 0; mtc0_data = 0; mfc0_addr = 0; exc_code = 0; exc_pc = 0; irq_in = 0;
    repeat (2) @(posedge Clk); #1;
    rdchk("rst status", 5'd12, 32'h0);
    rdchk("rst cause", 5'd13, 32'h0);
    rdchk("rst epc", 5'd14, 32'h0);
    chk("rst pending", 32'(irq_pending), 32'h0);
    Reset = 1;
    tick();

    // Interrupt line 0 through the synchroniser
    mtc0(5'd12, 32'h0000_0401);
    irq_in = 6'b000001;
    tick(); tick();
    rdchk("ip2 set", 5'd13, 32'h0000_0400);
    chk("pending not yet", 32'(irq_pending), 32'h0);
    tick();
    chk("pending set", 32'(irq_pending), 32'h1);
    irq_in = 0;
    tick(); tick();
    chk("pending held", 32'(irq_pending), 32'h1);
    tick();
    chk("pending drop", 32'(irq_pending), 32'h0);

    irq_in = 6'b101010;
    tick(); tick();
    rdchk("ip pattern", 5'd13, 32'h0000_A800);
    irq_in = 0;
    tick(); tick(); tick();

    // Exception entry from a delay slot, then nested entry and ERET
    exc(5'd4, 30'h100, 1'b1);
    rdchk("exc epc", 5'd14, 32'h0000_03FC);
    rdchk("exc cause", 5'd13, 32'h8000_0010);
    chk("exc exl", 32'(exl_out), 32'h1);
    exc(5'd12, 30'h200, 1'b0);
    rdchk("nest epc", 5'd14, 32'h0000_03FC);
    rdchk("nest cause", 5'd13, 32'h8000_0030);
    eret = 1; tick(); eret = 0;
    chk("eret exl", 32'(exl_out), 32'h0);
    rdchk("eret epc", 5'd14, 32'h0000_03FC);

    // exc_req + eret + MTC0 in one cycle
    exc_req = 1; exc_code = 5'd12; exc_pc = 30'h200; exc_bd = 0;
    eret = 1; mtc0_we = 1; mtc0_addr = 5'd12; mtc0_data = 32'h0;
    tick();
    exc_req = 0; eret = 0; mtc0_we = 0;
    rdchk("prio status", 5'd12, 32'h0000_0403);
    rdchk("prio epc", 5'd14, 32'h0000_0800);
    rdchk("prio cause", 5'd13, 32'h0000_0030);
    eret = 1; tick(); eret = 0;

    // Software writes, read-only fields and unmapped registers
    mtc0(5'd14, 32'h0000_1237);
    rdchk("epc write", 5'd14, 32'h0000_1234);
    mtc0(5'd13, 32'hFFFF_FFFF);
    rdchk("cause write", 5'd13, 32'h0000_0330);
    mtc0(5'd5, 32'hFFFF_FFFF);
    rdchk("unmapped", 5'd5, 32'h0);
    rdchk("status keep", 5'd12, 32'h0000_0401);
`ifndef CP0_TIMER_EN
    rdchk("no count", 5'd9, 32'h0);
`endif
    mtc0(5'd12, 32'h0000_0301);
    tick();
    chk("sw pending", 32'(irq_pending), 32'h1);

    // Delay-slot entry at PC 0 wraps; entry also drops irq_pending
    exc(5'd0, 30'h0, 1'b1);
    rdchk("wrap epc", 5'd14, 32'hFFFF_FFFC);
    chk("exc clr pend", 32'(irq_pending), 32'h0);
    rdchk("wrap cause", 5'd13, 32'h8000_0300);

    // Asynchronous reset mid-run
    irq_in = 6'h3F;
    tick(); tick();
    #3 Reset = 0; #1;
    rdchk("arst status", 5'd12, 32'h0);
    rdchk("arst cause", 5'd13, 32'h0);
    rdchk("arst epc", 5'd14, 32'h0);
    chk("arst pending", 32'(irq_pending), 32'h0);
    chk("arst exl", 32'(exl_out), 32'h0);
    irq_in = 0;
    Reset = 1;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
